// File: rtl/timed_sched_pkg.sv
// Shared widths and the event record carried through the timed event scheduler.
package timed_sched_pkg;

    localparam int unsigned TS_WIDTH   = 64;
    localparam int unsigned DATA_WIDTH = 64;
    localparam int unsigned DEPTH      = 16;
    localparam int unsigned PTR_W      = $clog2(DEPTH);

    typedef struct packed {
        logic [TS_WIDTH-1:0]   ts;
        logic [DATA_WIDTH-1:0] data;
    } sched_event_t;

endpackage

// File: rtl/sched_fifo.sv
// Synchronous FIFO of scheduler events with a first-word-fall-through head.
module sched_fifo
    import timed_sched_pkg::*;
#(
    parameter int unsigned FIFO_DEPTH = DEPTH
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         flush,
    input  logic                         push,
    input  sched_event_t                 wr_event,
    input  logic                         pop,
    output sched_event_t                 head,
    output logic [$clog2(FIFO_DEPTH):0]  count,
    output logic                         full,
    output logic                         empty
);

    localparam int unsigned PW = $clog2(FIFO_DEPTH);
    localparam logic [PW:0] FullCount = FIFO_DEPTH[PW:0];

    sched_event_t    mem_q [FIFO_DEPTH];
    logic [PW-1:0]   wr_ptr_q;
    logic [PW-1:0]   rd_ptr_q;
    logic [PW:0]     count_q;
    logic            do_push;
    logic            do_pop;

    assign full    = (count_q == FullCount);
    assign empty   = (count_q == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign head    = mem_q[rd_ptr_q];
    assign count   = count_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else if (flush) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
            unique case ({do_push, do_pop})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
        end
    end

    // Storage is not reset; stale entries are never observed because empty gates the head.
    always_ff @(posedge clk) begin
        if (do_push && !flush) mem_q[wr_ptr_q] <= wr_event;
    end

endmodule

// File: rtl/timed_event_scheduler.sv
// Queues timestamped events and releases each one once the live counter reaches its timestamp.
module timed_event_scheduler #(
    parameter int unsigned TS_WIDTH   = timed_sched_pkg::TS_WIDTH,
    parameter int unsigned DATA_WIDTH = timed_sched_pkg::DATA_WIDTH,
    parameter int unsigned DEPTH      = timed_sched_pkg::DEPTH
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [TS_WIDTH-1:0]     counter,
    input  logic                    flush,
    input  logic                    s_valid,
    output logic                    s_ready,
    input  logic [TS_WIDTH-1:0]     s_timestamp,
    input  logic [DATA_WIDTH-1:0]   s_data,
    output logic                    m_valid,
    input  logic                    m_ready,
    output logic [TS_WIDTH-1:0]     m_timestamp,
    output logic [DATA_WIDTH-1:0]   m_data,
    output logic                    m_late,
    output logic [$clog2(DEPTH):0]  fill_level,
    output logic                    late_error,
    input  logic                    clear_error
);

    import timed_sched_pkg::*;

    sched_event_t              wr_event;
    sched_event_t              head;
    logic [$clog2(DEPTH):0]    count;
    logic                      fifo_full;
    logic                      fifo_empty;
    logic                      ready_q;
    logic                      push;
    logic                      pop;
    logic                      due;
    logic                      free;

    logic                      m_valid_q;
    logic [TS_WIDTH-1:0]       m_timestamp_q;
    logic [DATA_WIDTH-1:0]     m_data_q;
    logic                      m_late_q;
    logic                      late_error_q;

    assign wr_event.ts   = s_timestamp;
    assign wr_event.data = s_data;

    // ready_q holds s_ready low for the whole reset and until the first edge after it.
    assign s_ready = ready_q && !fifo_full;
    assign push    = s_valid && s_ready && !flush;
    assign due     = !fifo_empty && (counter >= head.ts);
    assign free    = !m_valid_q || m_ready;
    assign pop     = due && free && !flush;

    sched_fifo #(
        .FIFO_DEPTH (DEPTH)
    ) u_fifo (
        .clk      (clk),
        .reset    (reset),
        .flush    (flush),
        .push     (push),
        .wr_event (wr_event),
        .pop      (pop),
        .head     (head),
        .count    (count),
        .full     (fifo_full),
        .empty    (fifo_empty)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ready_q       <= 1'b0;
            m_valid_q     <= 1'b0;
            m_timestamp_q <= '0;
            m_data_q      <= '0;
            m_late_q      <= 1'b0;
            late_error_q  <= 1'b0;
        end else begin
            ready_q <= 1'b1;
            if (flush) begin
                m_valid_q <= 1'b0;
                m_late_q  <= 1'b0;
            end else if (pop) begin
                m_valid_q     <= 1'b1;
                m_timestamp_q <= head.ts;
                m_data_q      <= head.data;
                m_late_q      <= (counter != head.ts);
            end else if (m_ready) begin
                m_valid_q <= 1'b0;
            end
            // A late release in the same cycle as clear_error keeps the flag set.
            if (pop && (counter != head.ts)) begin
                late_error_q <= 1'b1;
            end else if (clear_error) begin
                late_error_q <= 1'b0;
            end
        end
    end

    assign m_valid     = m_valid_q;
    assign m_timestamp = m_timestamp_q;
    assign m_data      = m_data_q;
    assign m_late      = m_late_q;
    assign fill_level  = count;
    assign late_error  = late_error_q;

endmodule
